store_buffer_dm: RTL

- Sits between the CPU MEM stage and the word-only data memory: DM has a 10-bit word address, write-enable DMWr, combinational read, and writes on negedge.
- Accepts byte/half/word stores into a DEPTH-entry FIFO with byte enables.
- Drains one entry per cycle into DM by read-merge-write.
- Services byte/half/word loads with lane extraction and sign extension, and stalls the CPU on full or load-address hazards.

---
 rtl/mips_mem_pkg.sv | 40 ++++
 rtl/store_lane_align.sv | 35 +++
 rtl/store_buffer_dm.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage store path: size codes, buffer entry
// layout and the byte-enable / lane-steering helpers.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic [9:0]  waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: be_gen = 4'b0001 << a;
            SZ_HALF: be_gen = 4'b0011 << a;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_steer(input logic [1:0] size, input logic [1:0] a,
                                               input logic [31:0] data);
        case (size)
            SZ_BYTE: lane_steer = {24'h0, data[7:0]} << {a, 3'b000};
            SZ_HALF: lane_steer = {16'h0, data[15:0]} << {a, 3'b000};
            default: lane_steer = data;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane logic: store data steering and byte enables, plus load
// lane extraction with sign/zero extension.
module store_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sext,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdword,
    output logic [31:0] o_wlane,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_shifted;

    assign o_wlane    = lane_steer(i_size, i_addr_lo, i_wdata);
    assign o_be       = be_gen(i_size, i_addr_lo);
    assign o_misalign = misaligned(i_size, i_addr_lo);
    assign w_shifted  = i_rdword >> {i_addr_lo, 3'b000};

    always_comb begin
        o_rdata = w_shifted;
        case (i_size)
            SZ_BYTE: o_rdata = i_sext ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                      : {24'h0, w_shifted[7:0]};
            SZ_HALF: o_rdata = i_sext ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                      : {16'h0, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/store_buffer_dm.sv
// Store buffer in front of the word-only data memory: queues sub-word stores,
// drains them by read-merge-write and arbitrates the single DM port with loads.
module store_buffer_dm
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [11:0]   cpu_addr,
    input  logic [1:0]    cpu_size,
    input  logic          cpu_sext,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    output logic          cpu_misalign,
    output logic          dm_wr,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout,
    output logic          sb_empty
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    logic        w_full;
    logic        w_empty;
    logic        w_hit;
    logic        w_push;
    logic        w_drain;
    logic        w_load_dm;
    logic [31:0] w_wlane;
    logic [3:0]  w_be;
    logic [31:0] w_rdata;
    logic        w_misalign;
    sb_entry_t   w_head;

    store_lane_align u_align (
        .i_size     (cpu_size),
        .i_addr_lo  (cpu_addr[1:0]),
        .i_sext     (cpu_sext),
        .i_wdata    (cpu_wdata),
        .i_rdword   (dm_dout),
        .o_wlane    (w_wlane),
        .o_be       (w_be),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign)
    );

    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_head];

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_mem[i].waddr == cpu_addr[11:2])) w_hit = 1'b1;
        end
    end

    // A full buffer always drains; otherwise a clean load owns the port.
    assign w_load_dm = cpu_re & ~w_misalign & ~w_hit;
    assign w_drain   = ~w_empty & (w_full | ~w_load_dm);
    assign w_push    = cpu_we & ~w_full & ~w_misalign;

    assign dm_wr   = w_drain & ~rst;
    assign dm_addr = w_drain ? w_head.waddr[AW-1:0] : cpu_addr[AW+1:2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dm_din[i*8 +: 8] = w_head.be[i] ? w_head.data[i*8 +: 8] : dm_dout[i*8 +: 8];
        end
    end

    assign cpu_stall    = (cpu_we & ~w_misalign & w_full)
                        | (cpu_re & ~w_misalign & (w_hit | w_full));
    assign cpu_misalign = w_misalign;
    assign cpu_rdata    = w_misalign ? 32'h0 : w_rdata;
    assign sb_empty     = w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_vld   <= '0;
        end else begin
            if (w_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_drain);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= '{waddr: cpu_addr[11:2], data: w_wlane, be: w_be};
    end

endmodule
